sram_arbiter: RTL and testbench

// - Two-port arbiter directly upstream of sram_ctrl; shares the single 256Kx16 SRAM between the Hack CPU data port and the video line fetcher.
// - Video (real-time) has priority. A CPU starvation guard and a read->write bus-turnaround bubble are built in.
// - Returns read data to the owning port with a fixed latency.

---
 rtl/hack_mem_pkg.sv | 14 +
 rtl/sram_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared memory-side types for the Hack SRAM path.
// Owner tags travel with reads so returned data reaches the right port.
// Strobe constant for full-word accesses.
package hack_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID
  } mem_owner_t;

  localparam logic [1:0] STROBE_FULL = 2'b11;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter (video priority, CPU starvation guard, read->write turnaround bubble).
// Latency: gnt combinational; read data returned to the owning port 2 cycles after issue.
// Backpressure: requests are held until gnt; a losing port simply sees gnt low.
module sram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int AW           = 18,
  parameter int DW           = 16,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [AW-1:0]   cpu_address,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            vid_req,
  input  logic [AW-1:0]   vid_address,
  output logic            vid_gnt,
  output logic            vid_rvalid,
  output logic [DW-1:0]   vid_rdata,
  output logic            mem_read,
  output logic            mem_write,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_strobe,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  // Owner-tag pipe: tag0 = read issued last cycle (data on mem_rdata now),
  // tag1 = read whose data sits in an rdata register this cycle.
  mem_owner_t tag0_q, tag0_d;
  mem_owner_t tag1_q;
  logic       last_was_read_q;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] vid_rdata_q;

  logic cpu_pend;
  logic cpu_eligible;
  logic cpu_forced;
  logic cpu_win;
  logic vid_win;

  // A write arriving right after a read would collide with read data on the bus.
  assign cpu_pend     = cpu_read | cpu_write;
  assign cpu_eligible = cpu_pend & ~(cpu_write & last_was_read_q);
  assign cpu_forced   = cpu_pend & (wait_cnt_q == MAX_WAIT);

  // Arbitration: forced CPU, then video, then CPU. A forced CPU blocked by
  // turnaround idles the bus so video cannot steal its slot again.
  always_comb begin
    cpu_win = 1'b0;
    vid_win = 1'b0;
    if (!reset) begin
      if (cpu_forced) begin
        cpu_win = cpu_eligible;
      end else if (vid_req) begin
        vid_win = 1'b1;
      end else begin
        cpu_win = cpu_eligible;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign vid_gnt = vid_win;

  // Memory command mux of the granted port; write wins over read on the CPU side.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    mem_strobe  = '0;
    tag0_d      = OWN_NONE;
    if (cpu_win) begin
      mem_read    = ~cpu_write;
      mem_write   = cpu_write;
      mem_address = cpu_address;
      mem_wdata   = cpu_wdata;
      mem_strobe  = STROBE_FULL;
      tag0_d      = cpu_write ? OWN_NONE : OWN_CPU;
    end else if (vid_win) begin
      mem_read    = 1'b1;
      mem_address = vid_address;
      mem_strobe  = STROBE_FULL;
      tag0_d      = OWN_VID;
    end
  end

  // Starvation counter: counts lost cycles while the CPU waits, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_pend || cpu_win) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Control state: tag pipe, turnaround flag, starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag0_q          <= OWN_NONE;
      tag1_q          <= OWN_NONE;
      last_was_read_q <= 1'b0;
      wait_cnt_q      <= '0;
    end else begin
      tag0_q          <= tag0_d;
      tag1_q          <= tag0_q;
      last_was_read_q <= mem_read;
      wait_cnt_q      <= wait_cnt_d;
    end
  end

  // Capture returning read data into the owner's register; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      if (tag0_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
      if (tag0_q == OWN_VID) vid_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = ~reset & (tag1_q == OWN_CPU);
  assign vid_rvalid = ~reset & (tag1_q == OWN_VID);
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter with a one-cycle SRAM model.
// Each table row is one clock cycle: inputs applied, outputs compared mid-cycle.
// Multi-cycle corner cases (reset mid-read, pipe recovery) are hand-written.
module tb_sram_arbiter;
  import hack_mem_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_address;
  logic          vid_gnt, vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_strobe;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  sram_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_address(vid_address), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM contents: a fixed function of address, with one special word.
  function automatic logic [15:0] sram_word(input logic [17:0] a);
    return (a == 18'h00010) ? 16'hBEEF : (a[15:0] + 16'h1000);
  endfunction

  // SRAM model: data for a read issued in cycle N is on mem_rdata in N+1.
  always @(posedge clk) mem_rdata <= mem_read ? sram_word(mem_address) : 16'hDEAD;

  typedef struct {
    logic        rst, crd, cwr;
    logic [17:0] caddr;
    logic [15:0] cwd;
    logic        vreq;
    logic [17:0] vaddr;
    logic        cg, vg, mrd, mwr;
    logic [17:0] maddr;
    logic [15:0] mwd;
    logic        crv;
    logic [15:0] crdat;
    logic        vrv;
    logic [15:0] vrdat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, crd, cwr, input logic [17:0] caddr,
                              input logic [15:0] cwd, input logic vreq, input logic [17:0] vaddr,
                              input logic cg, vg, mrd, mwr, input logic [17:0] maddr,
                              input logic [15:0] mwd, input logic crv, input logic [15:0] crdat,
                              input logic vrv, input logic [15:0] vrdat);
    vec_t v;
    v.rst = rst; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.vreq = vreq; v.vaddr = vaddr;
    v.cg = cg; v.vg = vg; v.mrd = mrd; v.mwr = mwr; v.maddr = maddr; v.mwd = mwd;
    v.crv = crv; v.crdat = crdat; v.vrv = vrv; v.vrdat = vrdat;
    return v;
  endfunction

  function automatic vec_t idle(input logic crv, input logic [15:0] crdat,
                                input logic vrv, input logic [15:0] vrdat);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, crv, crdat, vrv, vrdat);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, crd, cwr, input logic [17:0] caddr, input logic [15:0] cwd,
                       input logic vreq, input logic [17:0] vaddr);
    reset = rst; cpu_read = crd; cpu_write = cwr; cpu_address = caddr; cpu_wdata = cwd;
    vid_req = vreq; vid_address = vaddr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    drive(1, 0, 0, 0, 0, 0, 0);

    // Reset with requests asserted, then first grant goes to video.
    tbl.push_back(mk(1, 1, 0, 18'h10, 0, 1, 18'h20000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 18'h10, 0, 1, 18'h20000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 18'h10, 0, 1, 18'h20000, 0, 1, 1, 0, 18'h20000, 0, 0, 0, 0, 0));
    // CPU read of 0x10 alone: data 0xBEEF two cycles later, single pulse.
    tbl.push_back(mk(0, 1, 0, 18'h10, 0, 0, 0, 1, 0, 1, 0, 18'h10, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 1, 16'h1000));
    tbl.push_back(idle(1, 16'hBEEF, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // Video burst of 8 words, returned in order with a 2-cycle offset.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 18'h20000 + 18'(i), 0, 1, 1, 0, 18'h20000 + 18'(i), 0,
                       0, 0, (i >= 2), 16'h1000 + 16'(i) - 16'd2));
    tbl.push_back(idle(0, 0, 1, 16'h1006));
    tbl.push_back(idle(0, 0, 1, 16'h1007));
    tbl.push_back(idle(0, 0, 0, 0));
    // Starvation: CPU read forced through on its 5th pending cycle.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 18'h100, 0, 1, 18'h20010, 0, 1, 1, 0, 18'h20010, 0,
                       0, 0, (i >= 2), 16'h1010));
    tbl.push_back(mk(0, 1, 0, 18'h100, 0, 1, 18'h20010, 1, 0, 1, 0, 18'h100, 0, 0, 0, 1, 16'h1010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 18'h20010, 0, 1, 1, 0, 18'h20010, 0, 0, 0, 1, 16'h1010));
    tbl.push_back(idle(1, 16'h1100, 0, 0));
    tbl.push_back(idle(0, 0, 1, 16'h1010));
    tbl.push_back(idle(0, 0, 0, 0));
    // Turnaround: write after a video read waits one bubble cycle.
    tbl.push_back(mk(0, 0, 1, 18'h5, 16'h1234, 1, 18'h20011, 0, 1, 1, 0, 18'h20011, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h5, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 18'h5, 16'h1234, 0, 0, 1, 0, 0, 1, 18'h5, 16'h1234, 0, 0, 1, 16'h1011));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // Forced write blocked by turnaround: idle cycle even with video requesting.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 1, 18'h6, 16'hABCD, 1, 18'h20012, 0, 1, 1, 0, 18'h20012, 0,
                       0, 0, (i >= 2), 16'h1012));
    tbl.push_back(mk(0, 0, 1, 18'h6, 16'hABCD, 1, 18'h20012, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1012));
    tbl.push_back(mk(0, 0, 1, 18'h6, 16'hABCD, 1, 18'h20012, 1, 0, 0, 1, 18'h6, 16'hABCD, 0, 0, 1, 16'h1012));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 18'h20020, 0, 1, 1, 0, 18'h20020, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 1, 16'h1020));
    // Read and write both asserted: the write is taken, no read data returns.
    tbl.push_back(mk(0, 1, 1, 18'h7, 16'h5555, 0, 0, 1, 0, 0, 1, 18'h7, 16'h5555, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));

    foreach (tbl[r]) begin
      @(posedge clk);
      #1;
      drive(tbl[r].rst, tbl[r].crd, tbl[r].cwr, tbl[r].caddr, tbl[r].cwd, tbl[r].vreq, tbl[r].vaddr);
      #1;
      chk("cpu_gnt", r, 32'(cpu_gnt), 32'(tbl[r].cg));
      chk("vid_gnt", r, 32'(vid_gnt), 32'(tbl[r].vg));
      chk("mem_read", r, 32'(mem_read), 32'(tbl[r].mrd));
      chk("mem_write", r, 32'(mem_write), 32'(tbl[r].mwr));
      chk("mem_address", r, 32'(mem_address), 32'(tbl[r].maddr));
      chk("mem_wdata", r, 32'(mem_wdata), 32'(tbl[r].mwd));
      chk("mem_strobe", r, 32'(mem_strobe), (tbl[r].cg | tbl[r].vg) ? 32'h3 : 32'h0);
      chk("cpu_rvalid", r, 32'(cpu_rvalid), 32'(tbl[r].crv));
      chk("vid_rvalid", r, 32'(vid_rvalid), 32'(tbl[r].vrv));
      if (tbl[r].crv) chk("cpu_rdata", r, 32'(cpu_rdata), 32'(tbl[r].crdat));
      if (tbl[r].vrv) chk("vid_rdata", r, 32'(vid_rdata), 32'(tbl[r].vrdat));
    end

    // Reset mid-read: video read in N, reset in N+1, nothing returns in N+2.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 18'h20030);
    #1 chk("midrst_vid_gnt", 0, 32'(vid_gnt), 32'h1);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    #1 chk("midrst_gnt_in_reset", 1, 32'({cpu_gnt, vid_gnt, mem_read, mem_write}), 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("midrst_vid_rvalid_n2", 2, 32'(vid_rvalid), 32'h0);
    for (int i = 3; i < 6; i++) begin
      @(posedge clk); #2;
      chk("midrst_pipe_empty", i, 32'({cpu_rvalid, vid_rvalid}), 32'h0);
    end

    // Pipe recovers: a fresh CPU read returns exactly 2 cycles after its grant.
    @(posedge clk); #1;
    drive(0, 1, 0, 18'h10, 0, 0, 0);
    #1 chk("recover_cpu_gnt", 0, 32'(cpu_gnt), 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 1;
    #1;
    while (!cpu_rvalid && n < 6) begin
      @(posedge clk); #2;
      n++;
    end
    chk("recover_latency", 0, 32'(n), 32'd2);
    chk("recover_rdata", 0, 32'(cpu_rdata), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
